// File: rtl/temp_scan_pkg.sv
// -----------------------------------------------------------------------------
// temp_scan_pkg
//   Shared definitions for the temperature-sensor scan controller:
//   FSM state encoding and default width constants.
//   Optional feature macro used by the controller: THRESH_ALARM_EN.
// -----------------------------------------------------------------------------
package temp_scan_pkg;

    localparam int N_SENS_DEF   = 4;
    localparam int TICK_W_DEF   = 12;
    localparam int DAC_W_DEF    = 6;
    localparam int SETTLE_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/temp_scan_next_idx.sv
// -----------------------------------------------------------------------------
// temp_scan_next_idx
//   Combinational search for the next enabled sensor.
//   Ports:
//     mask_i    - enabled sensors
//     cur_i     - current sensor index
//     next_o    - lowest set bit above cur_i, or the lowest set bit overall
//                 when nothing is set above (wrap-around)
//     is_last_o - no set bit above cur_i
//   With cur_i = N_SENS-1 the block returns the lowest set bit of the mask,
//   which the controller uses to pick the first sensor of a scan.
// -----------------------------------------------------------------------------
module temp_scan_next_idx #(
    parameter int N_SENS = 4,
    parameter int SEL_W  = 2
) (
    input  logic [N_SENS-1:0] mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              is_last_o
);

    logic [SEL_W-1:0] low_idx;
    logic [SEL_W-1:0] above_idx;

    // Scanning downwards leaves the lowest matching index in each result.
    always_comb begin
        low_idx   = cur_i;
        above_idx = cur_i;
        is_last_o = 1'b1;
        for (int k = N_SENS - 1; k >= 0; k--) begin
            if (mask_i[k]) begin
                low_idx = SEL_W'(k);
                if (k > int'(cur_i)) begin
                    above_idx = SEL_W'(k);
                    is_last_o = 1'b0;
                end
            end
        end
        next_o = is_last_o ? low_idx : above_idx;
    end

endmodule

// File: rtl/temp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// temp_scan_ctrl
//   Round-robin scheduler for a shared N_SENS:1 temperature-sensor mux.
//   Selects a sensor, waits settle_cyc_i+1 cycles, captures ticks/DAC code and
//   offers the sample on a valid/ready interface. Continuous (enable_i) and
//   one-shot (single_i) scans.
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     enable_i, single_i  continuous scan / one-shot start pulse
//     sens_mask_i         sensors in a scan (latched at scan start)
//     settle_cyc_i        extra settle cycles (latched at scan start)
//     temp_sel_o          mux select
//     temp_ticks_i/dac_i  mux output data
//     sample_*            captured sample, valid/ready handshake
//     busy_o              scan in progress
//     scan_done_o         pulse after the last sample of a scan is accepted
//   Optional (macro THRESH_ALARM_EN):
//     thresh_hi_i, alarm_clr_i, alarm_o - sticky per-sensor over-threshold flags
// -----------------------------------------------------------------------------
module temp_scan_ctrl
    import temp_scan_pkg::*;
#(
    parameter  int N_SENS   = N_SENS_DEF,
    parameter  int TICK_W   = TICK_W_DEF,
    parameter  int DAC_W    = DAC_W_DEF,
    parameter  int SETTLE_W = SETTLE_W_DEF,
    localparam int SEL_W    = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                single_i,
    input  logic [N_SENS-1:0]   sens_mask_i,
    input  logic [SETTLE_W-1:0] settle_cyc_i,
    output logic [SEL_W-1:0]    temp_sel_o,
    input  logic [TICK_W-1:0]   temp_ticks_i,
    input  logic [DAC_W-1:0]    temp_dac_i,
    output logic                sample_valid_o,
    input  logic                sample_ready_i,
    output logic [SEL_W-1:0]    sample_sel_o,
    output logic [TICK_W-1:0]   sample_ticks_o,
    output logic [DAC_W-1:0]    sample_dac_o,
    output logic                busy_o,
    output logic                scan_done_o
`ifdef THRESH_ALARM_EN
    ,
    input  logic [TICK_W-1:0]   thresh_hi_i,
    input  logic                alarm_clr_i,
    output logic [N_SENS-1:0]   alarm_o
`endif
);

    state_t              state_q,  state_d;
    logic [SETTLE_W-1:0] cnt_q,    cnt_d;
    logic [N_SENS-1:0]   mask_q,   mask_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SEL_W-1:0]    sel_q,    sel_d;
    logic                valid_q,  valid_d;
    logic [SEL_W-1:0]    ssel_q,   ssel_d;
    logic [TICK_W-1:0]   ticks_q,  ticks_d;
    logic [DAC_W-1:0]    dac_q,    dac_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
`ifdef THRESH_ALARM_EN
    logic [N_SENS-1:0]   alarm_q,  alarm_d;
`endif

    logic [SEL_W-1:0]    start_idx;
    logic [SEL_W-1:0]    next_idx;
    logic                is_last;
    logic                start_unused;
    logic                handshake;

    // First sensor of a new scan: searching from the top index wraps to the
    // lowest set bit of the incoming mask.
    temp_scan_next_idx #(.N_SENS(N_SENS), .SEL_W(SEL_W)) u_first_idx (
        .mask_i    (sens_mask_i),
        .cur_i     (SEL_W'(N_SENS - 1)),
        .next_o    (start_idx),
        .is_last_o (start_unused)
    );

    // Successor of the sensor currently held, within the latched mask.
    temp_scan_next_idx #(.N_SENS(N_SENS), .SEL_W(SEL_W)) u_next_idx (
        .mask_i    (mask_q),
        .cur_i     (sel_q),
        .next_o    (next_idx),
        .is_last_o (is_last)
    );

    assign handshake = valid_q & sample_ready_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        settle_d = settle_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        ssel_d   = ssel_q;
        ticks_d  = ticks_q;
        dac_d    = dac_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((enable_i | single_i) && (sens_mask_i != '0)) begin
                    mask_d   = sens_mask_i;
                    settle_d = settle_cyc_i;
                    sel_d    = start_idx;
                    cnt_d    = settle_cyc_i;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            ST_CAPTURE: begin
                ssel_d  = sel_q;
                ticks_d = temp_ticks_i;
                dac_d   = temp_dac_i;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (is_last) begin
                        done_d = 1'b1;
                        // Back-to-back scans re-latch mask and settle time.
                        if (enable_i && (sens_mask_i != '0)) begin
                            mask_d   = sens_mask_i;
                            settle_d = settle_cyc_i;
                            sel_d    = start_idx;
                            cnt_d    = settle_cyc_i;
                            state_d  = ST_SETTLE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sel_d   = next_idx;
                        cnt_d   = settle_q;
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);

`ifdef THRESH_ALARM_EN
        // A set in the capture cycle overrides a simultaneous clear.
        alarm_d = alarm_clr_i ? '0 : alarm_q;
        if ((state_q == ST_CAPTURE) && (temp_ticks_i > thresh_hi_i)) begin
            alarm_d[sel_q] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            settle_q <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            ssel_q   <= '0;
            ticks_q  <= '0;
            dac_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef THRESH_ALARM_EN
            alarm_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            settle_q <= settle_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            ssel_q   <= ssel_d;
            ticks_q  <= ticks_d;
            dac_q    <= dac_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef THRESH_ALARM_EN
            alarm_q  <= alarm_d;
`endif
        end
    end

    assign temp_sel_o     = sel_q;
    assign sample_valid_o = valid_q;
    assign sample_sel_o   = ssel_q;
    assign sample_ticks_o = ticks_q;
    assign sample_dac_o   = dac_q;
    assign busy_o         = busy_q;
    assign scan_done_o    = done_q;
`ifdef THRESH_ALARM_EN
    assign alarm_o        = alarm_q;
`endif

endmodule

// File: tb/tb_temp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_temp_scan_ctrl
//   Self-checking bench for temp_scan_ctrl. Sensor mux is modelled by a fixed
//   per-index ticks/DAC pattern (with optional offset or forced ticks value).
//   Alarm checks are compiled when THRESH_ALARM_EN is defined.
// -----------------------------------------------------------------------------
module tb_temp_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        single;
    logic [3:0]  sens_mask;
    logic [7:0]  settle;
    logic [1:0]  temp_sel;
    logic [11:0] temp_ticks;
    logic [5:0]  temp_dac;
    logic        sample_valid;
    logic        sample_ready;
    logic [1:0]  sample_sel;
    logic [11:0] sample_ticks;
    logic [5:0]  sample_dac;
    logic        busy;
    logic        scan_done;
`ifdef THRESH_ALARM_EN
    logic [11:0] thresh_hi;
    logic        alarm_clr;
    logic [3:0]  alarm;
`endif

    logic [11:0] tick_ofs;
    logic        force_en;
    logic [11:0] force_val;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    temp_scan_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .single_i       (single),
        .sens_mask_i    (sens_mask),
        .settle_cyc_i   (settle),
        .temp_sel_o     (temp_sel),
        .temp_ticks_i   (temp_ticks),
        .temp_dac_i     (temp_dac),
        .sample_valid_o (sample_valid),
        .sample_ready_i (sample_ready),
        .sample_sel_o   (sample_sel),
        .sample_ticks_o (sample_ticks),
        .sample_dac_o   (sample_dac),
        .busy_o         (busy),
        .scan_done_o    (scan_done)
`ifdef THRESH_ALARM_EN
        ,
        .thresh_hi_i    (thresh_hi),
        .alarm_clr_i    (alarm_clr),
        .alarm_o        (alarm)
`endif
    );

    function automatic logic [11:0] base_ticks(input logic [1:0] s);
        return 12'h100 + 12'(s) * 12'h011;
    endfunction

    function automatic logic [5:0] base_dac(input logic [1:0] s);
        return 6'h20 + 6'(s) * 6'd5;
    endfunction

    function automatic logic [11:0] exp_ticks(input logic [1:0] s);
        return force_en ? force_val : (base_ticks(s) + tick_ofs);
    endfunction

    // Sensor mux model
    always_comb begin
        temp_ticks = exp_ticks(temp_sel);
        temp_dac   = base_dac(temp_sel);
    end

    typedef struct {
        logic [3:0] mask;
        logic [7:0] settle;
        int         n;
        logic [7:0] seq;   // expected sensor order, entry i at [2*i +: 2]
        int         lat;   // cycles from select change to valid
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for the next sample, then checks latency and contents.
    task automatic wait_sample(input string tag, input logic [1:0] es, input int lat);
        int c = 0;
        while (sample_valid !== 1'b1 && c < 64) begin
            step();
            c++;
        end
        check({tag, " latency"}, 32'(c), 32'(lat));
        check({tag, " temp_sel"}, 32'(temp_sel), 32'(es));
        check({tag, " sample_sel"}, 32'(sample_sel), 32'(es));
        check({tag, " ticks"}, 32'(sample_ticks), 32'(exp_ticks(es)));
        check({tag, " dac"}, 32'(sample_dac), 32'(base_dac(es)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " temp_sel"}, 32'(temp_sel), 0);
        check({tag, " valid"}, 32'(sample_valid), 0);
        check({tag, " sample_sel"}, 32'(sample_sel), 0);
        check({tag, " ticks"}, 32'(sample_ticks), 0);
        check({tag, " dac"}, 32'(sample_dac), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(scan_done), 0);
`ifdef THRESH_ALARM_EN
        check({tag, " alarm"}, 32'(alarm), 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic any_busy;
        logic any_valid;

        vecs[0] = '{4'b1111, 8'd3, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 5};
        vecs[1] = '{4'b1010, 8'd0, 2, {2'd0, 2'd0, 2'd3, 2'd1}, 2};
        vecs[2] = '{4'b0100, 8'd1, 1, {2'd0, 2'd0, 2'd0, 2'd2}, 3};
        vecs[3] = '{4'b1001, 8'd5, 2, {2'd0, 2'd0, 2'd3, 2'd0}, 7};
        vecs[4] = '{4'b0110, 8'd2, 2, {2'd0, 2'd0, 2'd2, 2'd1}, 4};

        rst          = 1'b1;
        enable       = 1'b0;
        single       = 1'b0;
        sens_mask    = 4'b0000;
        settle       = 8'd0;
        sample_ready = 1'b1;
        tick_ofs     = 12'h000;
        force_en     = 1'b0;
        force_val    = 12'h000;
`ifdef THRESH_ALARM_EN
        thresh_hi    = 12'h800;
        alarm_clr    = 1'b0;
`endif
        repeat (3) step();
        rst = 1'b0;
        check_all_zero("reset");

        // One-shot scans; mask/settle inputs change right after start to
        // confirm they are latched.
        for (int v = 0; v < 5; v++) begin
            sens_mask = vecs[v].mask;
            settle    = vecs[v].settle;
            single    = 1'b1;
            step();
            single    = 1'b0;
            sens_mask = 4'b1111;
            settle    = 8'd9;
            for (int i = 0; i < vecs[v].n; i++) begin
                wait_sample($sformatf("v%0d s%0d", v, i), vecs[v].seq[2*i +: 2], vecs[v].lat);
                check($sformatf("v%0d s%0d busy", v, i), 32'(busy), 1);
                check($sformatf("v%0d s%0d done", v, i), 32'(scan_done), 0);
                step();
            end
            check($sformatf("v%0d done pulse", v), 32'(scan_done), 1);
            check($sformatf("v%0d busy end", v), 32'(busy), 0);
            step();
            check($sformatf("v%0d done clear", v), 32'(scan_done), 0);
            check($sformatf("v%0d stay idle", v), 32'(busy), 0);
        end

        // Continuous scan, mask 1010: 1,3,1,3,... with done after every 3.
        sens_mask = 4'b1010;
        settle    = 8'd1;
        enable    = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            wait_sample($sformatf("cont %0d", k), (k % 2 == 1) ? 2'd3 : 2'd1, 3);
            step();
            check($sformatf("cont %0d done", k), 32'(scan_done), 32'(k % 2));
            check($sformatf("cont %0d busy", k), 32'(busy), 1);
        end
        // enable dropped mid-scan: remaining sensors still sampled
        enable = 1'b0;
        wait_sample("drop s0", 2'd1, 3);
        step();
        check("drop s0 done", 32'(scan_done), 0);
        wait_sample("drop s1", 2'd3, 3);
        step();
        check("drop done pulse", 32'(scan_done), 1);
        check("drop busy end", 32'(busy), 0);
        step();
        check("drop stay idle", 32'(busy), 0);

        // Backpressure: sample and select held while ready is low.
        sens_mask    = 4'b0011;
        settle       = 8'd0;
        sample_ready = 1'b0;
        single       = 1'b1;
        step();
        single = 1'b0;
        wait_sample("bp s0", 2'd0, 2);
        tick_ofs = 12'h040;
        for (int i = 0; i < 10; i++) begin
            single = (i == 3);
            step();
            check($sformatf("bp hold %0d valid", i), 32'(sample_valid), 1);
            check($sformatf("bp hold %0d ticks", i), 32'(sample_ticks), 32'h100);
            check($sformatf("bp hold %0d sel", i), 32'(temp_sel), 0);
        end
        sample_ready = 1'b1;
        step();
        check("bp after hs valid", 32'(sample_valid), 0);
        check("bp after hs sel", 32'(temp_sel), 1);
        wait_sample("bp s1", 2'd1, 2);
        step();
        check("bp done pulse", 32'(scan_done), 1);
        step();
        check("bp single ignored", 32'(busy), 0);
        tick_ofs = 12'h000;

        // Empty mask with enable: never starts.
        sens_mask = 4'b0000;
        enable    = 1'b1;
        any_busy  = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            any_busy  = any_busy | busy;
            any_valid = any_valid | sample_valid | scan_done;
        end
        check("mask0 busy", 32'(any_busy), 0);
        check("mask0 valid/done", 32'(any_valid), 0);
        enable = 1'b0;

        // Reset while holding a sample.
        sens_mask    = 4'b1111;
        sample_ready = 1'b0;
        single       = 1'b1;
        step();
        single = 1'b0;
        wait_sample("rst hold", 2'd0, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("rst in hold");
        step();
        check("rst hold idle", 32'(busy), 0);

        // Reset while settling.
        sens_mask = 4'b0100;
        settle    = 8'd20;
        single    = 1'b1;
        step();
        single = 1'b0;
        step();
        check("settle sel", 32'(temp_sel), 2);
        check("settle busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("rst in settle");
        sample_ready = 1'b1;
        settle       = 8'd0;

`ifdef THRESH_ALARM_EN
        force_en  = 1'b1;
        force_val = 12'h801;
        single    = 1'b1;
        step();
        single = 1'b0;
        wait_sample("alarm set", 2'd2, 2);
        check("alarm set", 32'(alarm), 32'h4);
        step();
        step();
        check("alarm sticky", 32'(alarm), 32'h4);
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        check("alarm clear", 32'(alarm), 0);

        force_val = 12'h800;
        single    = 1'b1;
        step();
        single = 1'b0;
        wait_sample("alarm equal", 2'd2, 2);
        check("alarm equal no set", 32'(alarm), 0);
        step();
        step();

        force_val = 12'h801;
        alarm_clr = 1'b1;
        single    = 1'b1;
        step();
        single = 1'b0;
        wait_sample("alarm set wins", 2'd2, 2);
        check("alarm set over clear", 32'(alarm), 32'h4);
        step();
        check("alarm clear after", 32'(alarm), 0);
        alarm_clr = 1'b0;
        force_en  = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
